// File: rtl/qmac_pkg.sv
// Shared constants for the Q-format sequential dot-product engine.
// FSM encoding plus saturation limits derived from the operand width.
// Pure definitions, no timing or flow-control content.
package qmac_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Largest positive value representable in an n-bit two's-complement word.
    function automatic longint sat_max(input int n);
        return (longint'(1) <<< (n - 1)) - longint'(1);
    endfunction

    // Most negative value representable in an n-bit two's-complement word.
    function automatic longint sat_min(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

endpackage

// File: rtl/qmult.sv
// Signed Q-format multiplier: full product rescaled by Q, wrapped to N bits.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the product is consumed.
module qmult #(
    parameter int N = 8,
    parameter int Q = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q_result,
    output logic         overflow
);

    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] scaled;
    logic        [N:0]     top_bits;

    always_comb begin
        prod     = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
        scaled   = prod >>> Q;
        q_result = scaled[N-1:0];
        // The rescaled product fits only if everything above the kept sign bit
        // is a copy of it; otherwise q_result has wrapped.
        top_bits = scaled[2*N-1:N-1];
        overflow = !((&top_bits) || (~|top_bits));
    end

endmodule

// File: rtl/qmac_seq.sv
// Sequential saturating Q-format dot product over up to MAXLEN operand pairs.
// Latency: result valid the cycle after the final operand handshake.
// Backpressure: in_valid/in_ready per pair, out_valid/out_ready on result; stalls unbounded.
module qmac_seq
    import qmac_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int Q      = 4,
    parameter  int MAXLEN = 16,
    localparam int LW     = $clog2(MAXLEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  result,
    output logic          ovf
);

    localparam int AW = N + LW;
    localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(N));
    localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(N));

    logic [1:0]           state;
    logic signed [AW-1:0] acc;
    logic [LW-1:0]        cnt;
    logic [LW-1:0]        len_q;
    logic                 sticky;
    logic [N-1:0]         result_q;
    logic                 ovf_q;

    logic [N-1:0]         q_result;
    logic                 q_ovf;
    logic                 hs;
    logic signed [AW-1:0] acc_next;
    logic [LW-1:0]        cnt_next;
    logic                 sticky_next;
    logic                 clamp_hi;
    logic                 clamp_lo;
    logic [N-1:0]         sat_val;

    qmult #(.N(N), .Q(Q)) u_qmult (
        .a        (a),
        .b        (b),
        .q_result (q_result),
        .overflow (q_ovf)
    );

    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign hs        = in_valid && in_ready;

    // Accumulator is LW bits wider than a product, so MAXLEN sums cannot wrap
    // and the clamp below sees the true total.
    always_comb begin
        acc_next    = acc + $signed({{LW{q_result[N-1]}}, q_result});
        cnt_next    = cnt + LW'(1);
        sticky_next = sticky || q_ovf;
        clamp_hi    = (acc_next > SAT_HI);
        clamp_lo    = (acc_next < SAT_LO);
        if (clamp_hi) begin
            sat_val = SAT_HI[N-1:0];
        end else if (clamp_lo) begin
            sat_val = SAT_LO[N-1:0];
        end else begin
            sat_val = acc_next[N-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            sticky   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        acc      <= '0;
                        cnt      <= '0;
                        sticky   <= 1'b0;
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                        state    <= (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        acc    <= acc_next;
                        cnt    <= cnt_next;
                        sticky <= sticky_next;
                        if (cnt_next == len_q) begin
                            result_q <= sat_val;
                            ovf_q    <= sticky_next || clamp_hi || clamp_lo;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qmac_seq.sv
// Directed bench for qmac_seq (N=8, Q=4) with hand-computed results.
module tb_qmac_seq;

    localparam int N  = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    qmac_seq #(.N(8), .Q(4), .MAXLEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // One pair per cycle; checks result/ovf the cycle after the last handshake.
    task automatic run_vec(input string tag, input int l, input logic [N-1:0] va,
                           input logic [N-1:0] vb, input logic [N-1:0] exp_res,
                           input logic exp_ovf);
        do_start(LW'(l));
        for (int i = 0; i < l; i++) begin
            in_valid = 1'b1;
            a        = va;
            b        = vb;
            if (i == 0) check({tag, " in_ready"}, {15'd0, in_ready}, 16'd1);
            tick();
        end
        in_valid = 1'b0;
        check({tag, " out_valid"}, {15'd0, out_valid}, 16'd1);
        check({tag, " result"},    {8'd0, result},     {8'd0, exp_res});
        check({tag, " ovf"},       {15'd0, ovf},       {15'd0, exp_ovf});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle"}, {14'd0, busy, out_valid}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        #2;
        check("reset outputs", {5'd0, busy, in_ready, out_valid, result}, 16'd0);
        check("reset ovf", {15'd0, ovf}, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1.0*2.0 three times = 6.0
        run_vec("len3 pos", 3, 8'h10, 8'h20, 8'h60, 1'b0);
        // -1.0*2.0 twice = -4.0
        run_vec("len2 neg", 2, 8'hF0, 8'h20, 8'hC0, 1'b0);
        // 2.0*2.0 four times = 16.0 clamps high
        run_vec("len4 clamp", 4, 8'h20, 8'h20, 8'h7F, 1'b1);
        // 4.0*4.0 = 16.0 wraps inside the multiplier to 0, overflow sticks
        run_vec("len1 qovf", 1, 8'h40, 8'h40, 8'h00, 1'b1);
        // -8.0*1.0 twice = -16.0 clamps low
        run_vec("len2 clamp lo", 2, 8'h80, 8'h10, 8'h80, 1'b1);
        // MAXLEN pairs: 7.0*16 = 112.0 with no accumulator wrap
        run_vec("len16 hi", 16, 8'h70, 8'h10, 8'h7F, 1'b1);
        run_vec("len16 lo", 16, 8'h80, 8'h10, 8'h80, 1'b1);

        // len=0 completes immediately with zero
        do_start('0);
        check("len0 out_valid", {15'd0, out_valid}, 16'd1);
        check("len0 result", {8'd0, result}, 16'd0);
        check("len0 ovf", {15'd0, ovf}, 16'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Gaps on input, ignored start/len while busy, stalled consumer
        do_start(5'd3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            start    = 1'b1;
            len      = 5'd1;
            tick();
            tick();
            start = 1'b0;
            check("gap in_ready", {14'd0, busy, in_ready}, 16'h3);
            check("gap no result", {15'd0, out_valid}, 16'd0);
            in_valid = 1'b1;
            a        = 8'h10;
            b        = 8'h20;
            tick();
        end
        in_valid = 1'b1;
        start    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall result", {7'd0, out_valid, result}, 16'h160);
            check("stall in_ready", {15'd0, in_ready}, 16'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("start on out hs ignored", {14'd0, busy, out_valid}, 16'd0);
        check("result held", {8'd0, result}, 16'h60);

        // Async reset after two handshakes discards the sum
        do_start(5'd3);
        in_valid = 1'b1;
        a = 8'h10;
        b = 8'h20;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst", {5'd0, busy, in_ready, out_valid, result}, 16'd0);
        check("async rst ovf", {15'd0, ovf}, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post rst idle", {15'd0, out_valid}, 16'd0);
        run_vec("fresh len1", 1, 8'h10, 8'h10, 8'h10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qmac_seq.md
QMAC_SEQ -- requirements
Module: qmac_seq

Interface
REQ-001 Parameter N, default 8: operand/result width, two's-complement fixed point.
REQ-002 Parameter Q, default 4: fractional bits.
REQ-003 Parameter MAXLEN, default 16: maximum dot-product length; LW = clog2(MAXLEN+1).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin a dot product; sampled only in IDLE.
REQ-007 len  in  LW  number of operand pairs; latched on accepted start.
REQ-008 busy  out  1  high in RUN and DONE.
REQ-009 in_valid  in  1  operand pair a/b valid.
REQ-010 in_ready  out  1  high only in RUN.
REQ-011 a, b  in  N each  Q-format operands.
REQ-012 out_valid  out  1  result available, high only in DONE.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 result  out  N  saturated dot-product sum.
REQ-015 ovf  out  1  sticky overflow for the current result.

Function
REQ-016 States: IDLE, RUN, DONE; registered state.
REQ-017 IDLE: start=1 with len>0 -> RUN; start=1 with len=0 -> DONE with result 0, ovf 0; clears accumulator, count, ovf on start.
REQ-018 One qmult(N,Q) instance is driven by a/b; product (q_result) and its overflow are consumed only on the in_valid&in_ready cycle.
REQ-019 Accumulator: signed, N+LW bits, adds sign-extended q_result on each handshake; no wrap is possible within MAXLEN.
REQ-020 Sticky ovf sets on any handshake whose qmult overflow=1.
REQ-021 RUN -> DONE on the handshake that makes count equal latched len; no operand is accepted after that handshake.
REQ-022 DONE: result = accumulator clamped to [-2^(N-1), 2^(N-1)-1]; ovf = sticky OR clamp-active; both registered, stable while out_valid=1.
REQ-023 Latency: out_valid asserts the cycle after the last handshake.
REQ-024 DONE -> IDLE on out_valid&out_ready; result and ovf hold their values until the next start.
REQ-025 start while busy ignored; len changes after latch have no effect.
REQ-026 in_valid low in RUN: no accumulate, no count; stall unbounded.
REQ-027 out_ready low in DONE: stall unbounded, no state change.
REQ-028 Same-cycle out handshake and start: start ignored (state is DONE).

Reset
REQ-029 rst=1 forces IDLE, accumulator 0, count 0, result 0, ovf 0, out_valid 0, in_ready 0, busy 0, immediately and independent of clk.
REQ-030 Reset mid-RUN or mid-DONE discards the partial sum; no result is emitted.

Structure
REQ-031 Package qmac_pkg holds state encoding and saturation limit constants as functions of N.
REQ-032 Sole sub-module is qmult, instantiated once; no other multiplier is inferred.

Verification (N=8, Q=4)
REQ-033 len=3, three pairs a=0x10, b=0x20 -> result 0x60, ovf 0, out_valid one cycle after third handshake.
REQ-034 len=2, pairs a=0xF0, b=0x20 -> result 0xC0, ovf 0.
REQ-035 len=4, pairs a=0x20, b=0x20 -> sum 16.0 clamps, result 0x7F, ovf 1.
REQ-036 len=1, a=0x40, b=0x40 -> qmult overflow, result 0x00, ovf 1; len=0 start -> result 0x00, ovf 0 next cycle.
REQ-037 len=3 with in_valid gaps and out_ready low 5 cycles -> result 0x60 held stable, in_ready low in DONE, extra start ignored.
REQ-038 rst pulse after second handshake of a len=3 run -> all outputs 0, IDLE; fresh len=1, a=0x10, b=0x10 -> 0x10.
